// File: rtl/pcpi_pkg.sv
// Shared definitions for the PCPI initiator: FSM states, RV32M decode
// constants and the default timeout window.
package pcpi_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [2:0] F3_DIV     = 3'b100;
    localparam logic [2:0] F3_DIVU    = 3'b101;
    localparam logic [2:0] F3_REM     = 3'b110;
    localparam logic [2:0] F3_REMU    = 3'b111;

    localparam int DEFAULT_TIMEOUT_CYCLES = 16;

endpackage

// File: rtl/pcpi_issue_ctrl.sv
// Core-side PCPI initiator. Takes one instruction from the pipeline, drives it
// onto the PCPI bus, waits for a responder and returns its result over a
// valid/ready port. An instruction nobody claims within the timeout window
// comes back as an illegal-instruction trap.
module pcpi_issue_ctrl
    import pcpi_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter int CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_insn,
    input  logic [31:0] req_rs1,
    input  logic [31:0] req_rs2,

    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic        rsp_wr,
    output logic [31:0] rsp_rd,
    output logic        rsp_trap,

    output logic        pcpi_valid,
    output logic [31:0] pcpi_insn,
    output logic [31:0] pcpi_rs1,
    output logic [31:0] pcpi_rs2,
    input  logic        pcpi_wr,
    input  logic [31:0] pcpi_rd,
    input  logic        pcpi_wait,
    input  logic        pcpi_ready
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state;
    state_e           state_next;
    logic [CNT_W-1:0] cnt;
    logic             claimed;

    logic             accept;
    logic             busy_ready;
    logic             idle_cycle;
    logic             expire;
    logic             rsp_done;

    // State register; reset aborts any transaction in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a ready pulse takes priority over timeout expiry.
    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept)                   state_next = BUSY;
            BUSY: if (busy_ready || expire)     state_next = RESP;
            RESP: if (rsp_done)                 state_next = IDLE;
            default:                            state_next = IDLE;
        endcase
    end

    // Decode of the current state into handshakes and the timeout condition.
    always_comb begin
        req_ready  = (state == IDLE);
        accept     = (state == IDLE) && req_valid;
        busy_ready = (state == BUSY) && pcpi_ready;
        idle_cycle = (state == BUSY) && !claimed && !pcpi_wait && !pcpi_ready;
        expire     = idle_cycle && (cnt == CNT_LAST);
        rsp_done   = (state == RESP) && rsp_ready;
    end

    // PCPI request registers; operands stay frozen while the responder works.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pcpi_valid <= 1'b0;
            pcpi_insn  <= '0;
            pcpi_rs1   <= '0;
            pcpi_rs2   <= '0;
        end else if (accept) begin
            pcpi_valid <= 1'b1;
            pcpi_insn  <= req_insn;
            pcpi_rs1   <= req_rs1;
            pcpi_rs2   <= req_rs2;
        end else if (busy_ready || expire) begin
            pcpi_valid <= 1'b0;
        end
    end

    // Timeout counter and sticky claim flag; a claim disables the timeout.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt     <= '0;
            claimed <= 1'b0;
        end else if (accept) begin
            cnt     <= '0;
            claimed <= 1'b0;
        end else if (state == BUSY) begin
            if (pcpi_wait) begin
                claimed <= 1'b1;
            end
            if (idle_cycle) begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    // Response registers, captured on ready or expiry and held until consumed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_wr    <= 1'b0;
            rsp_rd    <= '0;
            rsp_trap  <= 1'b0;
        end else if (busy_ready) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= pcpi_wr;
            rsp_rd    <= pcpi_wr ? pcpi_rd : 32'd0;
            rsp_trap  <= 1'b0;
        end else if (expire) begin
            rsp_valid <= 1'b1;
            rsp_wr    <= 1'b0;
            rsp_rd    <= '0;
            rsp_trap  <= 1'b1;
        end else if (rsp_done) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pcpi_issue_ctrl.sv
// Self-checking bench for pcpi_issue_ctrl. The bench plays both the core and
// the PCPI responder; expected responses come from an RV32M arithmetic model
// and a cycle-count model of when the responder answers or the timeout fires.
module tb_pcpi_issue_ctrl;
    import pcpi_pkg::*;

    localparam int TMO        = 16;
    localparam int MODE_NONE  = 0;
    localparam int MODE_FAST  = 1;
    localparam int MODE_CLAIM = 2;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_insn;
    logic [31:0] req_rs1;
    logic [31:0] req_rs2;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        rsp_wr;
    logic [31:0] rsp_rd;
    logic        rsp_trap;
    logic        pcpi_valid;
    logic [31:0] pcpi_insn;
    logic [31:0] pcpi_rs1;
    logic [31:0] pcpi_rs2;
    logic        pcpi_wr;
    logic [31:0] pcpi_rd;
    logic        pcpi_wait;
    logic        pcpi_ready;

    int checks = 0;
    int errors = 0;

    pcpi_issue_ctrl #(.TIMEOUT_CYCLES(TMO), .CNT_W(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_insn   (req_insn),
        .req_rs1    (req_rs1),
        .req_rs2    (req_rs2),
        .rsp_valid  (rsp_valid),
        .rsp_ready  (rsp_ready),
        .rsp_wr     (rsp_wr),
        .rsp_rd     (rsp_rd),
        .rsp_trap   (rsp_trap),
        .pcpi_valid (pcpi_valid),
        .pcpi_insn  (pcpi_insn),
        .pcpi_rs1   (pcpi_rs1),
        .pcpi_rs2   (pcpi_rs2),
        .pcpi_wr    (pcpi_wr),
        .pcpi_rd    (pcpi_rd),
        .pcpi_wait  (pcpi_wait),
        .pcpi_ready (pcpi_ready)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
        end
    endtask

    // RV32M divide/remainder semantics, including divide-by-zero and overflow.
    function automatic logic [31:0] ref_result(input logic [31:0] insn, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa;
        logic signed [31:0] sb;
        logic               ovf;
        sa  = $signed(a);
        sb  = $signed(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        case (insn[14:12])
            F3_DIV:  return (b == 0) ? 32'hFFFF_FFFF : (ovf ? a : 32'(sa / sb));
            F3_DIVU: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            F3_REM:  return (b == 0) ? a : (ovf ? 32'd0 : 32'(sa % sb));
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    // One full transaction: issue, responder behaviour, backpressured response.
    // FAST: ready at cycle d without wait. CLAIM: wait first seen at cycle c,
    // ready at cycle c+d. NONE: nobody answers.
    task automatic apply_stimulus(input logic [31:0] insn, input logic [31:0] rs1, input logic [31:0] rs2,
                                  input int mode, input int c, input int d, input logic wr,
                                  input logic [31:0] resp_val, input int bp);
        int          rdy_cyc;
        int          end_cyc;
        logic        exp_trap;
        logic        exp_wr;
        logic [31:0] exp_rd;

        rdy_cyc = 0;
        if (mode == MODE_FAST) rdy_cyc = d;
        if (mode == MODE_CLAIM && c <= TMO) rdy_cyc = c + d;
        if (rdy_cyc != 0 && (mode == MODE_CLAIM || rdy_cyc <= TMO)) begin
            end_cyc  = rdy_cyc;
            exp_trap = 1'b0;
            exp_wr   = wr;
            exp_rd   = wr ? resp_val : 32'd0;
        end else begin
            end_cyc  = TMO;
            exp_trap = 1'b1;
            exp_wr   = 1'b0;
            exp_rd   = 32'd0;
        end

        check_output("req_ready_idle", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_insn  = insn;
        req_rs1   = rs1;
        req_rs2   = rs2;
        tick();

        for (int k = 1; k <= end_cyc; k++) begin
            check_output("pcpi_valid_busy", 32'(pcpi_valid), 32'd1);
            check_output("pcpi_insn_hold", pcpi_insn, insn);
            check_output("pcpi_rs1_hold", pcpi_rs1, rs1);
            check_output("pcpi_rs2_hold", pcpi_rs2, rs2);
            check_output("rsp_valid_busy", 32'(rsp_valid), 32'd0);
            check_output("req_ready_busy", 32'(req_ready), 32'd0);
            req_valid  = 1'($urandom_range(0, 1));
            req_insn   = $urandom;
            req_rs1    = $urandom;
            req_rs2    = $urandom;
            pcpi_rd    = $urandom;
            pcpi_wr    = 1'($urandom_range(0, 1));
            pcpi_ready = 1'b0;
            pcpi_wait  = 1'b0;
            if (k == end_cyc && !exp_trap) begin
                pcpi_ready = 1'b1;
                pcpi_wr    = wr;
                pcpi_rd    = resp_val;
            end else if (mode == MODE_CLAIM && k >= c) begin
                pcpi_wait = (k == c) ? 1'b1 : 1'($urandom_range(0, 1));
            end
            tick();
        end

        req_valid = 1'b0;
        for (int j = 0; j <= bp; j++) begin
            check_output("rsp_valid", 32'(rsp_valid), 32'd1);
            check_output("rsp_trap", 32'(rsp_trap), 32'(exp_trap));
            check_output("rsp_wr", 32'(rsp_wr), 32'(exp_wr));
            check_output("rsp_rd", rsp_rd, exp_rd);
            check_output("pcpi_valid_resp", 32'(pcpi_valid), 32'd0);
            check_output("req_ready_resp", 32'(req_ready), 32'd0);
            pcpi_ready = 1'($urandom_range(0, 1));
            pcpi_wait  = 1'($urandom_range(0, 1));
            pcpi_wr    = 1'($urandom_range(0, 1));
            pcpi_rd    = $urandom;
            rsp_ready  = (j == bp);
            tick();
        end

        rsp_ready  = 1'b0;
        pcpi_ready = 1'b0;
        pcpi_wait  = 1'b0;
        check_output("rsp_valid_done", 32'(rsp_valid), 32'd0);
        check_output("req_ready_done", 32'(req_ready), 32'd1);
        check_output("pcpi_valid_done", 32'(pcpi_valid), 32'd0);
    endtask

    // Directed scenarios followed by randomized transactions.
    initial begin
        logic [31:0] insn;
        logic [31:0] a;
        logic [31:0] b;
        logic [2:0]  f3;
        int          mode;

        reset      = 1'b1;
        req_valid  = 1'b0;
        req_insn   = '0;
        req_rs1    = '0;
        req_rs2    = '0;
        rsp_ready  = 1'b0;
        pcpi_wr    = 1'b0;
        pcpi_rd    = '0;
        pcpi_wait  = 1'b0;
        pcpi_ready = 1'b0;

        #1;
        check_output("reset_pcpi_valid", 32'(pcpi_valid), 32'd0);
        check_output("reset_pcpi_insn", pcpi_insn, 32'd0);
        check_output("reset_pcpi_rs1", pcpi_rs1, 32'd0);
        check_output("reset_pcpi_rs2", pcpi_rs2, 32'd0);
        check_output("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("reset_rsp_wr", 32'(rsp_wr), 32'd0);
        check_output("reset_rsp_trap", 32'(rsp_trap), 32'd0);
        check_output("reset_rsp_rd", rsp_rd, 32'd0);
        check_output("reset_req_ready", 32'(req_ready), 32'd1);
        tick();
        tick();
        reset = 1'b0;
        tick();

        $display("[TB] directed transactions");
        apply_stimulus(32'h0220C1B3, 32'hFFFF_FFF9, 32'd2, MODE_CLAIM, 3, 32, 1'b1, 32'hFFFF_FFFD, 0);
        apply_stimulus(32'h0220F1B3, 32'd100, 32'd7, MODE_CLAIM, 3, 32, 1'b1, 32'd2, 1);
        apply_stimulus(32'h0220D1B3, 32'd5, 32'd0, MODE_CLAIM, 3, 32, 1'b1, 32'hFFFF_FFFF, 0);
        apply_stimulus(32'h002081B3, 32'd1, 32'd2, MODE_NONE, 0, 0, 1'b0, 32'd0, 10);
        apply_stimulus(32'h0220C1B3, 32'd40, 32'd6, MODE_CLAIM, 3, 32, 1'b1, 32'd6, 10);
        apply_stimulus(32'h0220C1B3, 32'd1, 32'd1, MODE_FAST, 0, TMO, 1'b1, 32'h1234_5678, 0);
        apply_stimulus(32'h0220C1B3, 32'd9, 32'd3, MODE_FAST, 0, TMO - 1, 1'b1, 32'd3, 0);
        apply_stimulus(32'h0220E1B3, 32'd9, 32'd4, MODE_CLAIM, TMO, 20, 1'b1, 32'd1, 0);
        apply_stimulus(32'h0220E1B3, 32'd9, 32'd4, MODE_CLAIM, TMO + 1, 5, 1'b1, 32'd1, 2);
        apply_stimulus(32'h0220C1B3, 32'd9, 32'd4, MODE_CLAIM, 2, 1, 1'b0, 32'hDEAD_BEEF, 0);

        $display("[TB] reset during a claimed transaction");
        req_valid = 1'b1;
        req_insn  = 32'h0220C1B3;
        req_rs1   = 32'd77;
        req_rs2   = 32'd7;
        tick();
        req_valid = 1'b0;
        tick();
        tick();
        pcpi_wait = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        check_output("claimed_still_busy", 32'(pcpi_valid), 32'd1);
        reset = 1'b1;
        #1;
        check_output("midreset_pcpi_valid", 32'(pcpi_valid), 32'd0);
        check_output("midreset_rsp_valid", 32'(rsp_valid), 32'd0);
        check_output("midreset_req_ready", 32'(req_ready), 32'd1);
        check_output("midreset_pcpi_insn", pcpi_insn, 32'd0);
        pcpi_wait = 1'b0;
        tick();
        tick();
        reset      = 1'b0;
        pcpi_ready = 1'b1;
        pcpi_wr    = 1'b1;
        pcpi_rd    = 32'd11;
        tick();
        pcpi_ready = 1'b0;
        pcpi_wr    = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_output("late_ready_rsp_valid", 32'(rsp_valid), 32'd0);
            check_output("late_ready_pcpi_valid", 32'(pcpi_valid), 32'd0);
            check_output("late_ready_req_ready", 32'(req_ready), 32'd1);
            tick();
        end

        $display("[TB] randomized transactions");
        for (int n = 0; n < 40; n++) begin
            a = $urandom;
            b = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) begin
                f3   = 3'($urandom_range(0, 7));
                insn = {7'b0000000, 5'($urandom), 5'($urandom), f3, 5'($urandom), OPC_OP};
                apply_stimulus(insn, a, b, MODE_NONE, 0, 0, 1'b0, 32'd0, $urandom_range(0, 4));
            end else begin
                f3   = 3'($urandom_range(4, 7));
                insn = {F7_MULDIV, 5'($urandom), 5'($urandom), f3, 5'($urandom), OPC_OP};
                mode = $urandom_range(1, 2);
                apply_stimulus(insn, a, b, mode, $urandom_range(1, 20),
                               (mode == MODE_FAST) ? $urandom_range(1, 20) : $urandom_range(0, 40),
                               ($urandom_range(0, 3) != 0), ref_result(insn, a, b),
                               $urandom_range(0, 4));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
